// File: rtl/downsample_2d_pool.sv
// 2D pooling downsampler: decimate, rounded mean or max over DEC_X x DEC_Y
// blocks of a raster stream, with valid/ready on both sides.
module downsample_2d_pool #(
    parameter int DATA_W    = 8,
    parameter int DEC_X     = 2,
    parameter int DEC_Y     = 2,
    parameter int IN_WIDTH  = 240,
    parameter int IN_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int LX    = $clog2(DEC_X);
    localparam int LY    = $clog2(DEC_Y);
    localparam int LN    = LX + LY;
    localparam int N     = DEC_X * DEC_Y;
    localparam int SUM_W = DATA_W + LN;
    localparam int OW    = IN_WIDTH / DEC_X;
    localparam int OCW   = (OW > 1) ? $clog2(OW) : 1;
    localparam int CW    = $clog2(IN_WIDTH + 1);
    localparam int RW    = $clog2(IN_HEIGHT + 1);

    localparam logic [CW-1:0]    COL_MAX  = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0]    ROW_MAX  = RW'(IN_HEIGHT - 1);
    localparam logic [CW-1:0]    DX_C     = CW'(DEC_X);
    localparam logic [RW-1:0]    DY_C     = RW'(DEC_Y);
    localparam logic [CW-1:0]    XPH_END  = CW'(DEC_X - 1);
    localparam logic [RW-1:0]    YPH_END  = RW'(DEC_Y - 1);
    localparam logic [CW-1:0]    LAST_COL = CW'(IN_WIDTH - DEC_X);
    localparam logic [RW-1:0]    LAST_ROW = RW'(IN_HEIGHT - DEC_Y);
    localparam logic [SUM_W-1:0] HALF_N   = SUM_W'(N / 2);

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [1:0]          mode_q, mode_d;
    logic [SUM_W-1:0]    h_acc_q, h_acc_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [SUM_W-1:0]    line_acc_q [OW];

    logic [CW-1:0]       x_ph;
    logic [RW-1:0]       y_ph;
    logic [OCW-1:0]      ocol;
    logic                first_px;
    logic                x_first, x_end, y_first, y_end;
    logic [1:0]          eff_mode;
    logic                is_mean, is_max, is_dec;
    logic                prod, acc, last_blk;

    logic [SUM_W-1:0]    in_ext, h_base, v_base, line_rd;
    logic [SUM_W-1:0]    h_sum, h_max, h_new;
    logic [SUM_W-1:0]    v_sum, v_max, v_new;
    logic [SUM_W-1:0]    rnd;
    logic [DATA_W-1:0]   emit_data;
    logic                line_we;

    // Block position
    assign x_ph     = col_q % DX_C;
    assign y_ph     = row_q % DY_C;
    assign ocol     = OCW'(col_q / DX_C);
    assign first_px = (col_q == '0) && (row_q == '0);
    assign x_first  = (x_ph == '0);
    assign y_first  = (y_ph == '0);
    assign x_end    = (x_ph == XPH_END);
    assign y_end    = (y_ph == YPH_END);
    assign last_blk = (col_q >= LAST_COL) && (row_q >= LAST_ROW);

    // The first pixel of a frame already runs in the mode it latches
    assign eff_mode = first_px ? mode : mode_q;
    assign is_mean  = (eff_mode == 2'd1);
    assign is_max   = (eff_mode == 2'd2);
    assign is_dec   = !is_mean && !is_max;

    assign prod     = is_dec ? (x_first && y_first) : (x_end && y_end);
    assign in_ready = !prod || !out_valid_q || out_ready;
    assign acc      = in_valid && in_ready;

    // Horizontal then vertical reduction; zero seeds hide stale partials
    assign in_ext  = SUM_W'(in_data);
    assign line_rd = line_acc_q[ocol];
    assign h_base  = x_first ? '0 : h_acc_q;
    assign h_sum   = h_base + in_ext;
    assign h_max   = (h_base > in_ext) ? h_base : in_ext;
    assign h_new   = is_max ? h_max : h_sum;
    assign v_base  = y_first ? '0 : line_rd;
    assign v_sum   = v_base + h_new;
    assign v_max   = (v_base > h_new) ? v_base : h_new;
    assign v_new   = is_max ? v_max : v_sum;
    assign rnd     = v_sum + HALF_N;

    always_comb begin
        emit_data = in_data;
        unique case (1'b1)
            is_mean: emit_data = DATA_W'(rnd >> LN);
            is_max:  emit_data = DATA_W'(v_max);
            default: emit_data = in_data;
        endcase
    end

    assign line_we = acc && !is_dec && x_end && !y_end;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        h_acc_d     = h_acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (acc) begin
            h_acc_d = h_new;
            if (first_px) begin
                mode_d = mode;
            end
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (acc && prod) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_data;
            out_last_d  = last_blk;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            h_acc_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            h_acc_q     <= h_acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line partials survive reset; they are always reseeded on y_ph==0
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_acc_q[ocol] <= v_new;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule
